alu_lane_sequencer: RTL and testbench

Vector-to-scalar issue unit in the Execute stage. Accepts one vector operation (LANES elements per operand, one 3-bit ALU op) over a valid/ready handshake and drives the lanes one per cycle into the existing combinational scalar ALU. It captures each lane's result and N/Z/V/C flags, then presents the assembled vector result and aggregate flags on an output valid/ready handshake. It is the initiator and consumer side of the ALU's A/B/sel → Out/NZVC interface.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_lane_sequencer_flags.sv | 53 +++++
 rtl/alu_lane_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_lane_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : shared state encoding and ALU op selects for the lane sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_MUL  = 3'b111;
    localparam logic [2:0] ALU_DIV  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b000;

endpackage

`default_nettype wire

// File: rtl/alu_lane_sequencer_flags.sv
// ============================================================================
// lane_flag_accum : accumulates per-lane ALU flags into vector-level N/Z/V/C
//                   plus a per-lane overflow mask
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_flag_accum #(
    parameter  int LANES = 4,
    localparam int IDX_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             merge,
    input  logic [IDX_W-1:0] lane_idx,
    input  logic             lane_n,
    input  logic             lane_z,
    input  logic             lane_v,
    input  logic             lane_c,
    output logic             acc_n,
    output logic             acc_z,
    output logic             acc_v,
    output logic             acc_c,
    output logic [LANES-1:0] vmask
);

    // Z starts at 1 because it is the AND across lanes; the others are ORs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_n <= 1'b0;
            acc_z <= 1'b1;
            acc_v <= 1'b0;
            acc_c <= 1'b0;
            vmask <= '0;
        end else if (clear) begin
            acc_n <= 1'b0;
            acc_z <= 1'b1;
            acc_v <= 1'b0;
            acc_c <= 1'b0;
            vmask <= '0;
        end else if (merge) begin
            acc_n           <= acc_n | lane_n;
            acc_z           <= acc_z & lane_z;
            acc_v           <= acc_v | lane_v;
            acc_c           <= acc_c | lane_c;
            vmask[lane_idx] <= lane_v;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_lane_sequencer.sv
// ============================================================================
// alu_lane_sequencer : issues one vector op lane-by-lane into a scalar ALU and
//                      returns the assembled vector result with merged flags
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_lane_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_sel,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_sel,
    input  logic [WIDTH-1:0]       alu_out,
    input  logic                   alu_n,
    input  logic                   alu_z,
    input  logic                   alu_v,
    input  logic                   alu_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_result,
    output logic                   out_n,
    output logic                   out_z,
    output logic                   out_v,
    output logic                   out_c,
    output logic [LANES-1:0]       out_vmask
);

    localparam int CNT_W = $clog2(LANES);

    seq_state_e             state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             sel_q;
    logic [LANES*WIDTH-1:0] a_q;
    logic [LANES*WIDTH-1:0] b_q;

    logic accept;
    logic running;
    logic last_lane;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign running   = (state == RUN);
    assign accept    = in_valid & in_ready;
    assign last_lane = (cnt == CNT_W'(LANES - 1));

    // The ALU sees quiet zero operands whenever no lane is in flight.
    assign alu_a   = running ? a_q[cnt*WIDTH +: WIDTH] : '0;
    assign alu_b   = running ? b_q[cnt*WIDTH +: WIDTH] : '0;
    assign alu_sel = running ? sel_q : ALU_PASS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sel_q      <= ALU_PASS;
            a_q        <= '0;
            b_q        <= '0;
            out_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sel_q <= in_sel;
                        a_q   <= in_a;
                        b_q   <= in_b;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    out_result[cnt*WIDTH +: WIDTH] <= alu_out;
                    // cnt parks on the last lane so it never wraps.
                    if (last_lane) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    lane_flag_accum #(
        .LANES (LANES)
    ) u_flags (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .merge    (running),
        .lane_idx (cnt),
        .lane_n   (alu_n),
        .lane_z   (alu_z),
        .lane_v   (alu_v),
        .lane_c   (alu_c),
        .acc_n    (out_n),
        .acc_z    (out_z),
        .acc_v    (out_v),
        .acc_c    (out_c),
        .vmask    (out_vmask)
    );

endmodule

`default_nettype wire

// File: tb/tb_alu_lane_sequencer.sv
// ============================================================================
// tb_alu_lane_sequencer : scoreboard bench with a behavioural scalar ALU on the
//                         alu_* port and a vector-level reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_lane_sequencer;
    import alu_seq_pkg::*;

    localparam int WIDTH = 18;
    localparam int LANES = 4;
    localparam int VW    = LANES * WIDTH;

    typedef struct packed {
        logic [VW-1:0]    res;
        logic             n;
        logic             z;
        logic             v;
        logic             c;
        logic [LANES-1:0] vm;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_sel;
    logic [VW-1:0]    in_a;
    logic [VW-1:0]    in_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_n, alu_z, alu_v, alu_c;
    logic             out_valid;
    wire              out_ready;
    logic [VW-1:0]    out_result;
    logic             out_n, out_z, out_v, out_c;
    logic [LANES-1:0] out_vmask;

    logic rand_mode   = 1'b0;
    logic ready_force = 1'b1;
    logic rand_bit    = 1'b0;
    assign out_ready = rand_mode ? rand_bit : ready_force;

    int   n_vec      = 0;
    int   n_bad      = 0;
    int   edges      = 0;
    int   acc_edge   = -100;
    logic prev_valid = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;
    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    alu_lane_sequencer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_n(out_n), .out_z(out_z), .out_v(out_v), .out_c(out_c), .out_vmask(out_vmask)
    );

    // Scalar ALU: returns {result, N, Z, V, C}; sub reports borrow on C.
    function automatic logic [WIDTH+3:0] alu_fn(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0]     wide;
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   r;
        logic               v, c;
        r = a; v = 1'b0; c = 1'b0;
        case (sel)
            ALU_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[WIDTH-1:0]; c = wide[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                r = wide[WIDTH-1:0]; c = wide[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_MUL: begin
                prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                r = prod[WIDTH-1:0]; c = |prod[2*WIDTH-1:WIDTH]; v = c;
            end
            ALU_DIV: begin
                if (b == '0) begin r = '1; v = 1'b1; end
                else r = a / b;
            end
            default: r = a;
        endcase
        return {r, r[WIDTH-1], (r == '0), v, c};
    endfunction

    always_comb {alu_out, alu_n, alu_z, alu_v, alu_c} = alu_fn(alu_sel, alu_a, alu_b);

    // Vector reference: apply the scalar op to every lane and fold the flags.
    function automatic exp_t model(input logic [2:0] sel, input logic [VW-1:0] a,
                                   input logic [VW-1:0] b);
        exp_t             e;
        logic [WIDTH+3:0] f;
        e = '0; e.z = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            f = alu_fn(sel, a[i*WIDTH +: WIDTH], b[i*WIDTH +: WIDTH]);
            e.res[i*WIDTH +: WIDTH] = f[WIDTH+3:4];
            e.n = e.n | f[3];
            e.z = e.z & f[2];
            e.v = e.v | f[1];
            e.c = e.c | f[0];
            e.vm[i] = f[1];
        end
        return e;
    endfunction

    function automatic logic [VW-1:0] pack4(input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1,
                                           input logic [WIDTH-1:0] l2, input logic [WIDTH-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic exp_t mk(input logic [VW-1:0] res, input logic n, input logic z,
                                input logic v, input logic c, input logic [LANES-1:0] vm);
        exp_t e;
        e.res = res; e.n = n; e.z = z; e.v = v; e.c = c; e.vm = vm;
        return e;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3))
                                                               : WIDTH'($urandom);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: checks lane issue, idle drive, latency, and result against the scoreboard.
    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            k = edges - acc_edge;
            if (k >= 0 && k < LANES) begin
                chk("lane_a", alu_a, in_a_hist[k*WIDTH +: WIDTH]);
                chk("lane_b", alu_b, in_b_hist[k*WIDTH +: WIDTH]);
                chk("lane_sel", alu_sel, sel_hist);
            end
            if (in_ready || out_valid)
                chk("alu_idle_drive", {alu_sel, alu_a, alu_b}, '0);
            if (out_valid) begin
                if (!prev_valid)
                    chk("latency", edges - acc_edge + 1, LANES + 1);
                chk("in_ready_in_done", in_ready, 1'b0);
                if (q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_out_valid: got result %h expected no output", out_result);
                end else begin
                    e = q[0];
                    chk("result", out_result, e.res);
                    chk("flags_nzvc_vmask", {out_n, out_z, out_v, out_c, out_vmask},
                        {e.n, e.z, e.v, e.c, e.vm});
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    logic [VW-1:0] in_a_hist, in_b_hist;
    logic [2:0]    sel_hist;

    task automatic issue(input logic [2:0] sel, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input exp_t e);
        int guard = 0;
        while (!in_ready && guard < 300) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
        end else begin
            in_valid = 1'b1; in_sel = sel; in_a = a; in_b = b;
            @(posedge clk); #1;
            in_a_hist = a; in_b_hist = b; sel_hist = sel;
            acc_edge = edges;
            q.push_back(e);
            // Scramble the inputs: they must have no effect once accepted.
            in_valid = 1'b0; in_sel = 3'($urandom); in_a = rand_vec(); in_b = rand_vec();
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((q.size() != 0 || !in_ready) && guard < 300) begin
            @(posedge clk); #1; guard++;
        end
        if (q.size() != 0 || !in_ready) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]    sels [7];
        logic [VW-1:0] ra, rb;
        logic [2:0]    rs;
        int            guard;
        sels[0] = ALU_ADD; sels[1] = ALU_SUB; sels[2] = ALU_MUL; sels[3] = ALU_DIV;
        sels[4] = ALU_PASS; sels[5] = 3'b010; sels[6] = 3'b001;
        in_a_hist = '0; in_b_hist = '0; sel_hist = '0;
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_a = '0; in_b = '0;

        @(posedge clk); #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_result", out_result, '0);
        chk("reset_flags", {out_n, out_z, out_v, out_c, out_vmask}, 8'b0100_0000);
        chk("reset_alu_drive", {alu_sel, alu_a, alu_b}, '0);
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #1;

        issue(ALU_ADD, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40),
              mk(pack4(11, 22, 33, 44), 0, 0, 0, 0, 4'b0000));
        wait_idle();
        issue(ALU_SUB, pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), mk('0, 0, 1, 0, 0, 4'b0000));
        wait_idle();
        issue(ALU_ADD, pack4(18'h1FFFF, 0, 0, 0), pack4(1, 0, 0, 0),
              mk(pack4(18'h20000, 0, 0, 0), 1, 0, 1, 0, 4'b0001));
        wait_idle();
        issue(ALU_PASS, pack4(7, 0, 9, 3), rand_vec(), mk(pack4(7, 0, 9, 3), 0, 0, 0, 0, 4'b0000));
        wait_idle();

        // Backpressure: result must hold while out_ready is low.
        ready_force = 1'b0;
        ra = pack4(100, 200, 300, 400); rb = pack4(1, 1, 1, 1);
        issue(ALU_ADD, ra, rb, mk(pack4(101, 201, 301, 401), 0, 0, 0, 0, 4'b0000));
        guard = 0;
        while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("bp_reached_done", out_valid, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_ready", in_ready, 1'b0);
        end
        ready_force = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_ready", in_ready, 1'b1);

        // Reset while lane 2 is on the ALU.
        issue(ALU_ADD, pack4(3, 3, 3, 3), pack4(4, 4, 4, 4), model(ALU_ADD, pack4(3, 3, 3, 3), pack4(4, 4, 4, 4)));
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1; acc_edge = -100; q.delete();
        #1;
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        chk("rst_mid_alu_sel", alu_sel, 3'b000);
        chk("rst_mid_result", out_result, '0);
        in_valid = 1'b1; in_sel = ALU_MUL; in_a = rand_vec(); in_b = rand_vec();
        repeat (2) @(posedge clk);
        #2; in_valid = 1'b0;
        #1; rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_accept", {in_ready, out_valid}, 2'b10);
        issue(ALU_ADD, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40),
              mk(pack4(11, 22, 33, 44), 0, 0, 0, 0, 4'b0000));
        wait_idle();

        // Randomised ops with random consumer backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rs = sels[$urandom_range(0, 6)];
            ra = rand_vec(); rb = rand_vec();
            issue(rs, ra, rb, model(rs, ra, rb));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_idle();
        rand_mode = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
